// File: rtl/tlb_pkg.sv
// Shared types and constants for the multi-port joint TLB.
package tlb_pkg;

    localparam int TLB_CONF_W = 86;
    localparam int TLB_LO_W   = 25;
    localparam int TLB_VPN2_W = 19;
    localparam int TLB_ASID_W = 8;

    // Cache attribute that marks a page uncached.
    localparam logic [2:0] C_UNCACHED = 3'd2;

    // Unmapped segment decode on vaddr[31:29] and the physical window mask.
    localparam logic [2:0]  SEG_KSEG0     = 3'b100;
    localparam logic [2:0]  SEG_KSEG1     = 3'b101;
    localparam logic [31:0] SEG_PHYS_MASK = 32'h1FFF_FFFF;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_lo_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [7:0]  rsvd;
        logic        g;
        tlb_lo_t     lo0;
        tlb_lo_t     lo1;
    } tlb_entry_t;

    typedef enum logic [0:0] {
        FL_IDLE  = 1'b0,
        FL_SWEEP = 1'b1
    } flush_state_e;

    // Convert a CP0 entry image to a stored entry; reserved bits never reach the array.
    function automatic tlb_entry_t tlb_sanitize(input logic [TLB_CONF_W-1:0] img);
        tlb_entry_t e;
        e      = tlb_entry_t'(img);
        e.rsvd = 8'h00;
        return e;
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Associative compare of one VPN2/ASID against every TLB entry.
// Reports the hit vector, the lowest matching index, a multi-hit flag and
// the even/odd lo half of the lowest matching entry.
module tlb_match
    import tlb_pkg::*;
#(
    parameter  int NUM_ENTRIES = 16,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES*TLB_CONF_W-1:0] entries_i,
    input  logic [TLB_VPN2_W-1:0]             vpn2_i,
    input  logic                              odd_i,
    input  logic [TLB_ASID_W-1:0]             asid_i,
    output logic [NUM_ENTRIES-1:0]            hit_vec_o,
    output logic [IDX_W-1:0]                  idx_o,
    output logic                              multi_o,
    output logic [TLB_LO_W-1:0]               lo_o
);

    tlb_entry_t ent_s;
    logic       found_s;
    logic       first_s;

    // Scan entries in ascending order so the first hit seen is the lowest index.
    always_comb begin
        hit_vec_o = '0;
        idx_o     = '0;
        multi_o   = 1'b0;
        lo_o      = '0;
        found_s   = 1'b0;
        first_s   = 1'b0;
        ent_s     = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_s        = tlb_entry_t'(entries_i[i*TLB_CONF_W +: TLB_CONF_W]);
            hit_vec_o[i] = (ent_s.vpn2 == vpn2_i) && (ent_s.g || (ent_s.asid == asid_i));
            first_s      = hit_vec_o[i] & ~found_s;
            multi_o      = multi_o | (hit_vec_o[i] & found_s);
            idx_o        = first_s ? IDX_W'(i) : idx_o;
            lo_o         = first_s ? (odd_i ? ent_s.lo1 : ent_s.lo0) : lo_o;
            found_s      = found_s | hit_vec_o[i];
        end
    end

endmodule

// File: rtl/tlb_multiport.sv
// Shared joint TLB: one entry array, NUM_LOOKUP translation ports, a probe
// path, TLBR readback and a one-entry-per-cycle invalidate-all engine.
module tlb_multiport
    import tlb_pkg::*;
#(
    parameter  int NUM_ENTRIES = 16,
    parameter  int NUM_LOOKUP  = 4,
    parameter  int LOOKUP_REG  = 1,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tlbwi,
    input  logic                    tlbwr,
    input  logic                    tlbp,
    input  logic                    tlbr,
    input  logic                    flush_req,
    output logic                    busy,
    input  logic [7:0]              curr_ASID,
    input  logic [NUM_LOOKUP*32-1:0] lookup_vaddr,
    output logic [NUM_LOOKUP*32-1:0] lookup_paddr,
    output logic [NUM_LOOKUP-1:0]   lookup_miss,
    output logic [NUM_LOOKUP-1:0]   lookup_valid,
    output logic [NUM_LOOKUP-1:0]   lookup_dirty,
    output logic [NUM_LOOKUP-1:0]   lookup_uncached,
    output logic                    probe_done,
    output logic                    probe_miss,
    output logic                    probe_multi,
    output logic [IDX_W-1:0]        probe_index,
    input  logic [IDX_W-1:0]        cp0_index,
    input  logic [IDX_W-1:0]        cp0_random,
    input  logic [TLB_CONF_W-1:0]   cp0_tlb_conf_in,
    output logic [TLB_CONF_W-1:0]   cp0_tlb_conf_out
);

    // ------------------------------------------------------------------
    // Array and flush engine state
    // ------------------------------------------------------------------
    tlb_entry_t [NUM_ENTRIES-1:0] entries_q, entries_d;
    flush_state_e                 state_q, state_d;
    logic [IDX_W-1:0]             cnt_q, cnt_d;
    tlb_entry_t                   sweep_e_s;

    logic idle_s;
    logic cmd_tlbp_s;
    logic cmd_tlbr_s;

    // CP0 commands are only honoured while the flush engine is idle.
    assign idle_s     = (state_q == FL_IDLE);
    assign cmd_tlbp_s = tlbp & idle_s;
    assign cmd_tlbr_s = tlbr & idle_s;
    assign busy       = (state_q == FL_SWEEP);

    // Next array contents and flush sequencing; flush beats tlbwi beats tlbwr.
    always_comb begin
        entries_d = entries_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        sweep_e_s = entries_q[cnt_q];
        case (state_q)
            FL_IDLE: begin
                if (flush_req) begin
                    state_d = FL_SWEEP;
                    cnt_d   = '0;
                end else if (tlbwi) begin
                    entries_d[cp0_index] = tlb_sanitize(cp0_tlb_conf_in);
                end else if (tlbwr) begin
                    entries_d[cp0_random] = tlb_sanitize(cp0_tlb_conf_in);
                end else begin
                    entries_d = entries_q;
                end
            end
            FL_SWEEP: begin
                sweep_e_s.g      = 1'b0;
                sweep_e_s.lo0.v  = 1'b0;
                sweep_e_s.lo1.v  = 1'b0;
                entries_d[cnt_q] = sweep_e_s;
                if (cnt_q == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_d = FL_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = FL_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Array, flush state and sweep counter; reset clears everything, even mid-sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q <= '0;
            state_q   <= FL_IDLE;
            cnt_q     <= '0;
        end else begin
            entries_q <= entries_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Probe path: sees the array as it was before this cycle's write
    // ------------------------------------------------------------------
    logic [NUM_ENTRIES-1:0] pr_hit_vec_s;
    logic [IDX_W-1:0]       pr_idx_s;
    logic                   pr_multi_s;
    logic [TLB_LO_W-1:0]    pr_lo_unused_s;

    tlb_match #(.NUM_ENTRIES(NUM_ENTRIES)) u_probe_match (
        .entries_i (entries_q),
        .vpn2_i    (cp0_tlb_conf_in[85:67]),
        .odd_i     (1'b0),
        .asid_i    (cp0_tlb_conf_in[66:59]),
        .hit_vec_o (pr_hit_vec_s),
        .idx_o     (pr_idx_s),
        .multi_o   (pr_multi_s),
        .lo_o      (pr_lo_unused_s)
    );

    logic                  probe_done_q, probe_miss_q, probe_multi_q;
    logic [IDX_W-1:0]      probe_index_q;
    logic [TLB_CONF_W-1:0] conf_out_q;

    // Capture probe results and pulse probe_done for one cycle after tlbp.
    always_ff @(posedge clk) begin
        if (rst) begin
            probe_done_q  <= 1'b0;
            probe_miss_q  <= 1'b0;
            probe_multi_q <= 1'b0;
            probe_index_q <= '0;
        end else begin
            probe_done_q <= cmd_tlbp_s;
            if (cmd_tlbp_s) begin
                probe_miss_q  <= ~|pr_hit_vec_s;
                probe_multi_q <= pr_multi_s;
                probe_index_q <= pr_idx_s;
            end
        end
    end

    // TLBR readback register; holds until the next accepted tlbr.
    always_ff @(posedge clk) begin
        if (rst) begin
            conf_out_q <= '0;
        end else if (cmd_tlbr_s) begin
            conf_out_q <= entries_q[cp0_index];
        end
    end

    assign probe_done       = probe_done_q;
    assign probe_miss       = probe_miss_q;
    assign probe_multi      = probe_multi_q;
    assign probe_index      = probe_index_q;
    assign cp0_tlb_conf_out = conf_out_q;

    // ------------------------------------------------------------------
    // Translation ports
    // ------------------------------------------------------------------
    logic [NUM_ENTRIES-1:0] lk_hit_vec_s     [NUM_LOOKUP];
    logic [IDX_W-1:0]       lk_idx_unused_s  [NUM_LOOKUP];
    logic                   lk_multi_unused_s[NUM_LOOKUP];
    logic [TLB_LO_W-1:0]    lk_lo_raw_s      [NUM_LOOKUP];

    for (genvar g = 0; g < NUM_LOOKUP; g++) begin : g_lookup
        tlb_match #(.NUM_ENTRIES(NUM_ENTRIES)) u_lookup_match (
            .entries_i (entries_q),
            .vpn2_i    (lookup_vaddr[32*g+13 +: 19]),
            .odd_i     (lookup_vaddr[32*g+12]),
            .asid_i    (curr_ASID),
            .hit_vec_o (lk_hit_vec_s[g]),
            .idx_o     (lk_idx_unused_s[g]),
            .multi_o   (lk_multi_unused_s[g]),
            .lo_o      (lk_lo_raw_s[g])
        );
    end

    logic [NUM_LOOKUP*32-1:0] lk_paddr_s;
    logic [NUM_LOOKUP-1:0]    lk_miss_s, lk_valid_s, lk_dirty_s, lk_unc_s;
    logic [31:0]              va_s;
    tlb_lo_t                  lo_s;

    // Per-port translation: unmapped kseg0/kseg1 first, then the TLB result.
    always_comb begin
        lk_paddr_s = '0;
        lk_miss_s  = '0;
        lk_valid_s = '0;
        lk_dirty_s = '0;
        lk_unc_s   = '0;
        va_s       = '0;
        lo_s       = '0;
        for (int p = 0; p < NUM_LOOKUP; p++) begin
            va_s = lookup_vaddr[32*p +: 32];
            lo_s = tlb_lo_t'(lk_lo_raw_s[p]);
            if ((va_s[31:29] == SEG_KSEG0) || (va_s[31:29] == SEG_KSEG1)) begin
                lk_paddr_s[32*p +: 32] = va_s & SEG_PHYS_MASK;
                lk_miss_s[p]           = 1'b0;
                lk_valid_s[p]          = 1'b1;
                lk_dirty_s[p]          = 1'b1;
                lk_unc_s[p]            = (va_s[31:29] == SEG_KSEG1);
            end else if (|lk_hit_vec_s[p]) begin
                lk_paddr_s[32*p +: 32] = {lo_s.pfn, va_s[11:0]};
                lk_miss_s[p]           = 1'b0;
                lk_valid_s[p]          = lo_s.v;
                lk_dirty_s[p]          = lo_s.d;
                lk_unc_s[p]            = (lo_s.c == C_UNCACHED);
            end else begin
                lk_paddr_s[32*p +: 32] = 32'h0000_0000;
                lk_miss_s[p]           = 1'b1;
                lk_valid_s[p]          = 1'b0;
                lk_dirty_s[p]          = 1'b0;
                lk_unc_s[p]            = 1'b0;
            end
        end
    end

    if (LOOKUP_REG != 0) begin : g_lookup_reg
        logic [NUM_LOOKUP*32-1:0] paddr_q;
        logic [NUM_LOOKUP-1:0]    miss_q, valid_q, dirty_q, unc_q;

        // One-cycle registered translation results.
        always_ff @(posedge clk) begin
            if (rst) begin
                paddr_q <= '0;
                miss_q  <= '0;
                valid_q <= '0;
                dirty_q <= '0;
                unc_q   <= '0;
            end else begin
                paddr_q <= lk_paddr_s;
                miss_q  <= lk_miss_s;
                valid_q <= lk_valid_s;
                dirty_q <= lk_dirty_s;
                unc_q   <= lk_unc_s;
            end
        end

        assign lookup_paddr    = paddr_q;
        assign lookup_miss     = miss_q;
        assign lookup_valid    = valid_q;
        assign lookup_dirty    = dirty_q;
        assign lookup_uncached = unc_q;
    end else begin : g_lookup_comb
        assign lookup_paddr    = lk_paddr_s;
        assign lookup_miss     = lk_miss_s;
        assign lookup_valid    = lk_valid_s;
        assign lookup_dirty    = lk_dirty_s;
        assign lookup_uncached = lk_unc_s;
    end

endmodule

// File: tb/tb_tlb_multiport.sv
// Self-checking bench for tlb_multiport with a behavioural TLB model.
module tb_tlb_multiport;

    localparam int NE = 16;
    localparam int NL = 4;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst, tlbwi, tlbwr, tlbp, tlbr, flush_req, busy;
    logic [7:0]      curr_ASID;
    logic [NL*32-1:0] lookup_vaddr, lookup_paddr;
    logic [NL-1:0]   lookup_miss, lookup_valid, lookup_dirty, lookup_uncached;
    logic            probe_done, probe_miss, probe_multi;
    logic [IW-1:0]   probe_index, cp0_index, cp0_random;
    logic [85:0]     conf_in, conf_out;

    int n_vec = 0;
    int n_err = 0;

    logic [85:0] m_img [NE];

    always #5 clk = ~clk;

    tlb_multiport #(.NUM_ENTRIES(NE), .NUM_LOOKUP(NL), .LOOKUP_REG(1)) dut (
        .clk(clk), .rst(rst), .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp), .tlbr(tlbr),
        .flush_req(flush_req), .busy(busy), .curr_ASID(curr_ASID),
        .lookup_vaddr(lookup_vaddr), .lookup_paddr(lookup_paddr),
        .lookup_miss(lookup_miss), .lookup_valid(lookup_valid),
        .lookup_dirty(lookup_dirty), .lookup_uncached(lookup_uncached),
        .probe_done(probe_done), .probe_miss(probe_miss), .probe_multi(probe_multi),
        .probe_index(probe_index), .cp0_index(cp0_index), .cp0_random(cp0_random),
        .cp0_tlb_conf_in(conf_in), .cp0_tlb_conf_out(conf_out)
    );

    // ---------------- reference model ----------------
    function automatic logic [24:0] mk_lo(logic [19:0] pfn, logic [2:0] c, logic d, logic v);
        return {pfn, c, d, v};
    endfunction

    function automatic logic [85:0] mk_img(logic [18:0] vpn2, logic [7:0] asid, logic [7:0] rsvd,
                                           logic g, logic [24:0] lo0, logic [24:0] lo1);
        return {vpn2, asid, rsvd, g, lo0, lo1};
    endfunction

    function automatic logic [85:0] strip(logic [85:0] img);
        logic [85:0] r;
        r = img;
        r[58:51] = 8'h00;
        return r;
    endfunction

    function automatic logic [85:0] rand_img();
        return mk_img(19'($urandom_range(0, 7)), 8'($urandom_range(1, 3)), 8'($urandom),
                      ($urandom_range(0, 3) == 0),
                      mk_lo(20'($urandom), 3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom)),
                      mk_lo(20'($urandom), 3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom)));
    endfunction

    function automatic logic [31:0] rand_va();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return {3'b100, 29'($urandom)};
        if (r == 1) return {3'b101, 29'($urandom)};
        return {19'($urandom_range(0, 7)), 13'($urandom)};
    endfunction

    // Expected {paddr, miss, valid, dirty, uncached} for one address.
    function automatic logic [35:0] model_lk(logic [31:0] va, logic [7:0] asid);
        logic [85:0] e;
        logic [24:0] lo;
        if (va[31:29] == 3'b100) return {va & 32'h1FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        if (va[31:29] == 3'b101) return {va & 32'h1FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < NE; i++) begin
            e = m_img[i];
            if (e[85:67] == va[31:13] && (e[50] || e[66:59] == asid)) begin
                lo = va[12] ? e[24:0] : e[49:25];
                return {lo[24:5], va[11:0], 1'b0, lo[0], lo[1], (lo[4:2] == 3'd2)};
            end
        end
        return {32'h0, 1'b1, 3'b000};
    endfunction

    // Expected {miss, multi, index} of a probe.
    function automatic logic [5:0] model_probe(logic [18:0] vpn2, logic [7:0] asid);
        int cnt;
        logic [3:0] idx;
        cnt = 0;
        idx = 4'd0;
        for (int i = 0; i < NE; i++) begin
            if (m_img[i][85:67] == vpn2 && (m_img[i][50] || m_img[i][66:59] == asid)) begin
                if (cnt == 0) idx = 4'(i);
                cnt++;
            end
        end
        return {(cnt == 0), (cnt > 1), idx};
    endfunction

    function automatic logic [35:0] dut_lk(int p);
        return {lookup_paddr[32*p +: 32], lookup_miss[p], lookup_valid[p],
                lookup_dirty[p], lookup_uncached[p]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic rnd, input logic [3:0] idx, input logic [85:0] img);
        if (rnd) begin
            tlbwr = 1'b1; cp0_random = idx;
        end else begin
            tlbwi = 1'b1; cp0_index = idx;
        end
        conf_in = img;
        step();
        tlbwi = 1'b0; tlbwr = 1'b0;
        m_img[idx] = strip(img);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; tlbwi = 1'b0; tlbwr = 1'b0; tlbp = 1'b0; tlbr = 1'b0; flush_req = 1'b0;
        curr_ASID = 8'h00; cp0_index = '0; cp0_random = '0; conf_in = '0;
        lookup_vaddr = {32'hA000_0010, 32'h8000_0020, 32'hA123_4567, 32'h8765_4321};
        step(); step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if ({probe_done, probe_miss, probe_multi, probe_index} !== 7'h0) begin
            n_err++; $display("FAIL reset_probe: got %b%b%b %h want 0", probe_done, probe_miss, probe_multi, probe_index); end
        n_vec++; if (conf_out !== 86'h0) begin n_err++; $display("FAIL reset_conf_out: got %h want 0", conf_out); end
        for (int p = 0; p < NL; p++) begin
            n_vec++; if (dut_lk(p) !== 36'h0) begin n_err++; $display("FAIL reset_lookup%0d: got %h want 0", p, dut_lk(p)); end
        end
        rst = 1'b0;
        for (int i = 0; i < NE; i++) m_img[i] = '0;
        step();
    endtask

    task automatic test_write_translate();
        logic [35:0] exp_lk [NL];
        wr(1'b0, 4'd3, mk_img(19'h00010, 8'h05, 8'h00, 1'b0, 25'h0, mk_lo(20'h12345, 3'd3, 1'b1, 1'b1)));
        curr_ASID = 8'h05;
        for (int p = 0; p < NL; p++) lookup_vaddr[32*p +: 32] = rand_va();
        lookup_vaddr[64 +: 32] = 32'h0002_1ABC;
        for (int p = 0; p < NL; p++) exp_lk[p] = model_lk(lookup_vaddr[32*p +: 32], curr_ASID);
        step();
        n_vec++; if (dut_lk(2) !== {32'h1234_5ABC, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL translate_port2: got %h want %h", dut_lk(2), {32'h1234_5ABC, 4'b0110}); end
        for (int p = 0; p < NL; p++) begin
            n_vec++; if (dut_lk(p) !== exp_lk[p]) begin n_err++; $display("FAIL translate_model%0d: got %h want %h", p, dut_lk(p), exp_lk[p]); end
        end
    endtask

    task automatic test_asid_global();
        curr_ASID = 8'h06;
        step();
        n_vec++; if (dut_lk(2) !== {32'h0, 1'b1, 3'b000}) begin n_err++; $display("FAIL asid_mismatch: got %h want miss", dut_lk(2)); end
        wr(1'b0, 4'd3, mk_img(19'h00010, 8'h05, 8'h00, 1'b1, 25'h0, mk_lo(20'h12345, 3'd3, 1'b1, 1'b1)));
        step();
        n_vec++; if (dut_lk(2) !== {32'h1234_5ABC, 4'b0110}) begin n_err++; $display("FAIL global_asid6: got %h want hit", dut_lk(2)); end
        curr_ASID = 8'h05;
        step();
        n_vec++; if (dut_lk(2) !== {32'h1234_5ABC, 4'b0110}) begin n_err++; $display("FAIL global_asid5: got %h want hit", dut_lk(2)); end
    endtask

    task automatic test_probe();
        logic [5:0] exp_pr;
        wr(1'b0, 4'd2, mk_img(19'h41234, 8'h01, 8'h00, 1'b1, mk_lo(20'h1, 3'd0, 1'b0, 1'b1), 25'h0));
        wr(1'b0, 4'd9, mk_img(19'h41234, 8'h02, 8'h00, 1'b1, mk_lo(20'h2, 3'd0, 1'b0, 1'b1), 25'h0));
        conf_in = mk_img(19'h41234, 8'h77, 8'h00, 1'b0, 25'h0, 25'h0);
        exp_pr = model_probe(19'h41234, 8'h77);
        tlbp = 1'b1; step(); tlbp = 1'b0;
        n_vec++; if ({probe_done, probe_miss, probe_multi, probe_index} !== {1'b1, 1'b0, 1'b1, 4'd2}) begin
            n_err++; $display("FAIL probe_multi: got %b%b%b %h want 101 2", probe_done, probe_miss, probe_multi, probe_index); end
        n_vec++; if ({probe_miss, probe_multi, probe_index} !== exp_pr) begin
            n_err++; $display("FAIL probe_multi_model: got %h want %h", {probe_miss, probe_multi, probe_index}, exp_pr); end
        step();
        n_vec++; if (probe_done !== 1'b0) begin n_err++; $display("FAIL probe_done_pulse: got %b want 0", probe_done); end
        conf_in = mk_img(19'h55555, 8'h01, 8'h00, 1'b0, 25'h0, 25'h0);
        tlbp = 1'b1; step(); tlbp = 1'b0;
        n_vec++; if ({probe_done, probe_miss, probe_multi, probe_index} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
            n_err++; $display("FAIL probe_miss: got %b%b%b %h want 110 0", probe_done, probe_miss, probe_multi, probe_index); end
    endtask

    task automatic test_kseg_readback();
        logic [85:0] img;
        logic [7:0]  rsvd;
        lookup_vaddr = {32'h9234_5678, 32'hBFFF_FFFF, 32'h8000_2000, 32'hA000_1000};
        step();
        n_vec++; if (dut_lk(0) !== {32'h0000_1000, 4'b0111}) begin n_err++; $display("FAIL kseg1: got %h want %h", dut_lk(0), {32'h0000_1000, 4'b0111}); end
        n_vec++; if (dut_lk(1) !== {32'h0000_2000, 4'b0110}) begin n_err++; $display("FAIL kseg0: got %h want %h", dut_lk(1), {32'h0000_2000, 4'b0110}); end
        n_vec++; if (dut_lk(2) !== {32'h1FFF_FFFF, 4'b0111}) begin n_err++; $display("FAIL kseg1_top: got %h want %h", dut_lk(2), {32'h1FFF_FFFF, 4'b0111}); end
        n_vec++; if (dut_lk(3) !== {32'h1234_5678, 4'b0110}) begin n_err++; $display("FAIL kseg0_mid: got %h want %h", dut_lk(3), {32'h1234_5678, 4'b0110}); end
        img = mk_img(19'h00010, 8'h05, 8'hA5, 1'b0, mk_lo(20'hABCDE, 3'd2, 1'b0, 1'b1), mk_lo(20'h12345, 3'd3, 1'b1, 1'b1));
        wr(1'b0, 4'd3, img);
        cp0_index = 4'd3; tlbr = 1'b1; step(); tlbr = 1'b0;
        n_vec++; if (conf_out !== strip(img)) begin n_err++; $display("FAIL tlbr_image: got %h want %h", conf_out, strip(img)); end
        rsvd = conf_out[58:51];
        n_vec++; if (rsvd !== 8'h00) begin n_err++; $display("FAIL tlbr_reserved: got %h want 00", rsvd); end
        wr(1'b1, 4'd3, rand_img());
        step();
        n_vec++; if (conf_out !== strip(img)) begin n_err++; $display("FAIL tlbr_hold: got %h want %h", conf_out, strip(img)); end
    endtask

    task automatic test_same_cycle();
        logic [85:0] old_img, new_img;
        logic [5:0]  exp_pr;
        old_img = m_img[4];
        new_img = mk_img(19'h60000, 8'h03, 8'h00, 1'b0, mk_lo(20'h77777, 3'd2, 1'b1, 1'b1), 25'h0);
        exp_pr  = model_probe(19'h60000, 8'h03);
        cp0_index = 4'd4; conf_in = new_img;
        tlbwi = 1'b1; tlbr = 1'b1; tlbp = 1'b1;
        step();
        tlbwi = 1'b0; tlbr = 1'b0; tlbp = 1'b0;
        m_img[4] = strip(new_img);
        n_vec++; if (conf_out !== old_img) begin n_err++; $display("FAIL same_cycle_tlbr: got %h want %h", conf_out, old_img); end
        n_vec++; if ({probe_done, probe_miss, probe_multi, probe_index} !== {1'b1, exp_pr}) begin
            n_err++; $display("FAIL same_cycle_tlbp: got %h want %h", {probe_done, probe_miss, probe_multi, probe_index}, {1'b1, exp_pr}); end
        tlbr = 1'b1; tlbp = 1'b1; step(); tlbr = 1'b0; tlbp = 1'b0;
        n_vec++; if (conf_out !== strip(new_img)) begin n_err++; $display("FAIL next_cycle_tlbr: got %h want %h", conf_out, strip(new_img)); end
        n_vec++; if ({probe_miss, probe_multi, probe_index} !== model_probe(19'h60000, 8'h03)) begin
            n_err++; $display("FAIL next_cycle_tlbp: got %h want %h", {probe_miss, probe_multi, probe_index}, model_probe(19'h60000, 8'h03)); end
    endtask

    task automatic test_random();
        logic [35:0] exp_lk [NL];
        logic [85:0] img, exp_conf;
        logic [5:0]  exp_pr;
        logic [3:0]  idx, ridx;
        int          op;
        for (int it = 0; it < 200; it++) begin
            op = $urandom_range(0, 4);
            curr_ASID = 8'($urandom_range(1, 3));
            for (int p = 0; p < NL; p++) lookup_vaddr[32*p +: 32] = rand_va();
            for (int p = 0; p < NL; p++) exp_lk[p] = model_lk(lookup_vaddr[32*p +: 32], curr_ASID);
            img = rand_img(); idx = 4'($urandom); ridx = 4'($urandom);
            conf_in = img; cp0_index = idx; cp0_random = ridx;
            exp_pr = model_probe(img[85:67], img[66:59]);
            exp_conf = m_img[idx];
            case (op)
                0: tlbwi = 1'b1;
                1: tlbwr = 1'b1;
                2: tlbp = 1'b1;
                3: tlbr = 1'b1;
                default: tlbwi = 1'b0;
            endcase
            step();
            tlbwi = 1'b0; tlbwr = 1'b0; tlbp = 1'b0; tlbr = 1'b0;
            for (int p = 0; p < NL; p++) begin
                n_vec++; if (dut_lk(p) !== exp_lk[p]) begin n_err++; $display("FAIL rand_lookup it%0d p%0d: got %h want %h", it, p, dut_lk(p), exp_lk[p]); end
            end
            if (op == 2) begin
                n_vec++; if ({probe_done, probe_miss, probe_multi, probe_index} !== {1'b1, exp_pr}) begin
                    n_err++; $display("FAIL rand_probe it%0d: got %h want %h", it, {probe_done, probe_miss, probe_multi, probe_index}, {1'b1, exp_pr}); end
            end else if (op == 3) begin
                n_vec++; if (conf_out !== exp_conf) begin n_err++; $display("FAIL rand_tlbr it%0d: got %h want %h", it, conf_out, exp_conf); end
            end else begin
                n_vec++; if (probe_done !== 1'b0) begin n_err++; $display("FAIL rand_probe_idle it%0d: got %b want 0", it, probe_done); end
            end
            if (op == 0) m_img[idx] = strip(img);
            if (op == 1) m_img[ridx] = strip(img);
        end
    endtask

    task automatic test_flush();
        logic [35:0] exp_lk [NL];
        logic [85:0] conf_before;
        int          cnt;
        for (int i = 0; i < NE; i++)
            wr(1'b0, 4'(i), mk_img(19'(32'h20 + i), 8'h11, 8'h00, 1'b1,
                                   mk_lo(20'($urandom), 3'd0, 1'b1, 1'b1), mk_lo(20'($urandom), 3'd1, 1'b0, 1'b1)));
        conf_before = conf_out;
        // flush together with a tlbwi: the write must lose
        conf_in = mk_img(19'h20, 8'h22, 8'h00, 1'b1, mk_lo(20'h1, 3'd0, 1'b1, 1'b1), mk_lo(20'h1, 3'd0, 1'b1, 1'b1));
        cp0_index = 4'd0; tlbwi = 1'b1; flush_req = 1'b1;
        step();
        tlbwi = 1'b0; flush_req = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            tlbwi = (cnt == 3);
            cp0_index = 4'd5;
            conf_in = (cnt == 5) ? mk_img(19'h21, 8'h11, 8'h00, 1'b0, 25'h0, 25'h0)
                                 : mk_img(19'h25, 8'h22, 8'h00, 1'b1, mk_lo(20'h5, 3'd0, 1'b1, 1'b1), 25'h0);
            tlbp = (cnt == 5);
            tlbr = (cnt == 7);
            flush_req = (cnt == 9);
            step();
            n_vec++; if (probe_done !== 1'b0) begin n_err++; $display("FAIL flush_probe_done cyc%0d: got %b want 0", cnt, probe_done); end
        end
        tlbwi = 1'b0; tlbp = 1'b0; tlbr = 1'b0; flush_req = 1'b0;
        n_vec++; if (cnt != 16) begin n_err++; $display("FAIL flush_busy_cycles: got %0d want 16", cnt); end
        n_vec++; if (conf_out !== conf_before) begin n_err++; $display("FAIL flush_tlbr_ignored: got %h want %h", conf_out, conf_before); end
        for (int i = 0; i < NE; i++) begin
            m_img[i][50] = 1'b0; m_img[i][25] = 1'b0; m_img[i][0] = 1'b0;
        end
        for (int a = 0; a < 2; a++) begin
            curr_ASID = (a == 0) ? 8'h22 : 8'h11;
            lookup_vaddr = {19'h2F, 13'h1004, 19'h2A, 13'h0008, 19'h25, 13'h1FF0, 19'h20, 13'h0123};
            for (int p = 0; p < NL; p++) exp_lk[p] = model_lk(lookup_vaddr[32*p +: 32], curr_ASID);
            step();
            for (int p = 0; p < NL; p++) begin
                n_vec++; if (dut_lk(p) !== exp_lk[p]) begin n_err++; $display("FAIL flush_lookup a%0d p%0d: got %h want %h", a, p, dut_lk(p), exp_lk[p]); end
                if (a == 0) begin
                    n_vec++; if (lookup_miss[p] !== 1'b1) begin n_err++; $display("FAIL flush_miss p%0d: got %b want 1", p, lookup_miss[p]); end
                end
            end
        end
    endtask

    task automatic test_reset_midsweep();
        logic [35:0] exp_lk [NL];
        for (int i = 0; i < NE; i++) wr(1'b1, 4'(i), rand_img());
        flush_req = 1'b1; step(); flush_req = 1'b0;
        repeat (7) step();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midsweep_busy: got %b want 1", busy); end
        lookup_vaddr = {32'hA000_0010, 32'h8000_0020, 32'hA123_4567, 32'h8765_4321};
        rst = 1'b1;
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midsweep_rst_busy: got %b want 0", busy); end
        n_vec++; if (conf_out !== 86'h0) begin n_err++; $display("FAIL midsweep_rst_conf: got %h want 0", conf_out); end
        n_vec++; if ({probe_done, probe_miss, probe_multi, probe_index} !== 7'h0) begin
            n_err++; $display("FAIL midsweep_rst_probe: got %h want 0", {probe_done, probe_miss, probe_multi, probe_index}); end
        for (int p = 0; p < NL; p++) begin
            n_vec++; if (dut_lk(p) !== 36'h0) begin n_err++; $display("FAIL midsweep_rst_lookup%0d: got %h want 0", p, dut_lk(p)); end
        end
        rst = 1'b0;
        for (int i = 0; i < NE; i++) m_img[i] = '0;
        step();
        wr(1'b0, 4'd7, mk_img(19'h3, 8'h09, 8'h00, 1'b0, mk_lo(20'hCAFE0, 3'd2, 1'b0, 1'b1), 25'h0));
        curr_ASID = 8'h09;
        lookup_vaddr = {19'h3, 13'h0444, 19'h5, 13'h0010, 19'h1, 13'h1000, 19'h3, 13'h1444};
        for (int p = 0; p < NL; p++) exp_lk[p] = model_lk(lookup_vaddr[32*p +: 32], curr_ASID);
        step();
        n_vec++; if (dut_lk(3) !== {32'hCAFE_0444, 4'b0101}) begin n_err++; $display("FAIL after_reset_hit: got %h want %h", dut_lk(3), {32'hCAFE_0444, 4'b0101}); end
        for (int p = 0; p < NL; p++) begin
            n_vec++; if (dut_lk(p) !== exp_lk[p]) begin n_err++; $display("FAIL after_reset_lookup%0d: got %h want %h", p, dut_lk(p), exp_lk[p]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_translate();
        test_asid_global();
        test_probe();
        test_kseg_readback();
        test_same_cycle();
        test_random();
        test_flush();
        test_reset_midsweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
